// File: rtl/ps2_keyboard_pkg.sv
// PS/2 scancode-set-2 constants, decoder state encoding and symbol lookup.
// Latency: n/a (declarations and a pure combinational helper).
// Backpressure: n/a.
package ps2_keyboard_pkg;

  // Prefix and command scancodes
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_BKSP   = 8'h66;
  localparam logic [7:0] PS2_LEFT   = 8'h6B;
  localparam logic [7:0] PS2_RIGHT  = 8'h74;

  // Keypad symbols, identical with or without shift
  localparam logic [7:0] PS2_KP_PLUS  = 8'h79;
  localparam logic [7:0] PS2_KP_STAR  = 8'h7C;
  localparam logic [7:0] PS2_KP_MINUS = 8'h7B;

  // Decoder state: what prefix bytes have been seen so far
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // Map a make code to 7-bit ASCII; 0 means the key produces no symbol.
  function automatic logic [6:0] ps2_symbol(input logic [7:0] code, input logic shift);
    logic [6:0] sym;
    sym = 7'h00;
    case (code)
      PS2_KP_PLUS:  sym = 7'h2B;
      PS2_KP_STAR:  sym = 7'h2A;
      PS2_KP_MINUS: sym = 7'h2D;
      default: begin
        if (shift) begin
          case (code)
            8'h55:   sym = 7'h2B; // '+'
            8'h3E:   sym = 7'h2A; // '*'
            8'h46:   sym = 7'h28; // '('
            8'h45:   sym = 7'h29; // ')'
            default: sym = 7'h00;
          endcase
        end else begin
          case (code)
            8'h45:   sym = 7'h30;
            8'h16:   sym = 7'h31;
            8'h1E:   sym = 7'h32;
            8'h26:   sym = 7'h33;
            8'h25:   sym = 7'h34;
            8'h2E:   sym = 7'h35;
            8'h36:   sym = 7'h36;
            8'h3D:   sym = 7'h37;
            8'h3E:   sym = 7'h38;
            8'h46:   sym = 7'h39;
            8'h22:   sym = 7'h78; // 'x'
            8'h4E:   sym = 7'h2D; // '-'
            8'h4A:   sym = 7'h2F; // '/'
            8'h49:   sym = 7'h2E; // '.'
            default: sym = 7'h00;
          endcase
        end
      end
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx.sv
// PS/2 frame receiver: synchronise pins, sample data on ps2_clk falls, validate 11-bit frames.
// Latency: o_byte_vld / o_frame_err 4 clk after the stop-bit falling edge at the pin.
// Backpressure: none; bytes arrive far slower than clk and are consumed immediately.
module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 25175
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_prev;
  logic          r_fall;
  logic          r_dat_smp;
  logic [10:0]   r_shift;
  logic [3:0]    r_bit_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_byte;
  logic          r_byte_vld;
  logic          r_frame_err;

  logic [10:0]   w_shift_nxt;
  logic          w_frame_ok;
  logic          w_to_hit;

  // Two-stage synchronisers; the bus idles high so reset them to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
    end
  end

  // Registered falling-edge strobe with the data bit aligned to it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_prev <= 1'b1;
      r_fall     <= 1'b0;
      r_dat_smp  <= 1'b1;
    end else begin
      r_clk_prev <= r_clk_sync[1];
      r_fall     <= r_clk_prev & ~r_clk_sync[1];
      r_dat_smp  <= r_dat_sync[1];
    end
  end

  // Bits arrive LSB first, so shift in from the top; after 11 bits [0]=start, [10]=stop
  assign w_shift_nxt = {r_dat_smp, r_shift[10:1]};
  assign w_frame_ok  = ~w_shift_nxt[0] & w_shift_nxt[10] & (^w_shift_nxt[9:1]);
  assign w_to_hit    = (r_bit_cnt != 4'd0) && (r_to_cnt == TO_LAST);

  // Frame assembly, frame check and partial-frame timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '1;
      r_bit_cnt   <= 4'd0;
      r_to_cnt    <= '0;
      r_byte      <= 8'h00;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_fall) begin
        r_to_cnt <= '0;
        r_shift  <= w_shift_nxt;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= 4'd0;
          if (w_frame_ok) begin
            r_byte     <= w_shift_nxt[8:1];
            r_byte_vld <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else begin
        // Saturate so a long idle bus never wraps back into a false timeout
        if (r_to_cnt != TO_LAST) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
        if (w_to_hit) begin
          r_bit_cnt   <= 4'd0;
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign o_byte      = r_byte;
  assign o_byte_vld  = r_byte_vld;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: decodes scancodes into left/right/backspace/symbol pulses.
// Latency: command pulse 1 clk after byte_valid, i.e. 5 clk after the stop-bit edge.
// Backpressure: none; every output is a single-cycle pulse the consumer must absorb.
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int SYMBOL_WIDTH   = 7,
  parameter int TIMEOUT_CYCLES = 25175
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  output logic                    left,
  output logic                    right,
  output logic                    backspace,
  output logic [SYMBOL_WIDTH-1:0] symbol,
  output logic                    frame_error
);

  logic [7:0]              w_byte;
  logic                    w_byte_vld;
  logic                    w_frame_err;

  dec_state_t              r_state;
  logic                    r_shift_held;
  logic                    r_left;
  logic                    r_right;
  logic                    r_bksp;
  logic [SYMBOL_WIDTH-1:0] r_sym;

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .o_byte      (w_byte),
    .o_byte_vld  (w_byte_vld),
    .o_frame_err (w_frame_err)
  );

  // Prefix-tracking decoder with registered single-cycle command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift_held <= 1'b0;
      r_left       <= 1'b0;
      r_right      <= 1'b0;
      r_bksp       <= 1'b0;
      r_sym        <= '0;
    end else begin
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_bksp  <= 1'b0;
      r_sym   <= '0;
      if (w_byte_vld) begin
        case (r_state)
          ST_IDLE: begin
            if (w_byte == PS2_EXT) begin
              r_state <= ST_EXT;
            end else if (w_byte == PS2_BRK) begin
              r_state <= ST_BRK;
            end else if (w_byte == PS2_LSHIFT || w_byte == PS2_RSHIFT) begin
              r_shift_held <= 1'b1;
            end else if (w_byte == PS2_BKSP) begin
              r_bksp <= 1'b1;
            end else begin
              // Unknown codes (including E1) map to 0 and so emit nothing
              r_sym <= SYMBOL_WIDTH'(ps2_symbol(w_byte, r_shift_held));
            end
          end
          ST_BRK: begin
            if (w_byte == PS2_LSHIFT || w_byte == PS2_RSHIFT) begin
              r_shift_held <= 1'b0;
            end
            r_state <= ST_IDLE;
          end
          ST_EXT: begin
            if (w_byte == PS2_BRK) begin
              r_state <= ST_EXT_BRK;
            end else begin
              r_left  <= (w_byte == PS2_LEFT);
              r_right <= (w_byte == PS2_RIGHT);
              r_state <= ST_IDLE;
            end
          end
          ST_EXT_BRK: r_state <= ST_IDLE;
          default:    r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign left        = r_left;
  assign right       = r_right;
  assign backspace   = r_bksp;
  assign symbol      = r_sym;
  assign frame_error = w_frame_err;

endmodule
